// File: rtl/sram_io_ctrl_chip_pkg.sv
// Shared types and defaults for the serial-to-SRAM bridge.
package sram_io_ctrl_chip_pkg;

  localparam int unsigned DEF_MEMORY_DATA_WIDTH = 8;
  localparam int unsigned DEF_MEMORY_ADDR_WIDTH = 10;
  localparam int unsigned DEF_REG_BITS_WIDTH    = DEF_MEMORY_ADDR_WIDTH + DEF_MEMORY_DATA_WIDTH;
  localparam int unsigned DEF_CNT_WIDTH         = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_RD_REQ = 3'd2,
    ST_RD_CAP = 3'd3,
    ST_WR_REQ = 3'd4
  } state_e;

  localparam logic [1:0] MODE_SER = 2'b00;
  localparam logic [1:0] MODE_RD  = 2'b01;
  localparam logic [1:0] MODE_WR  = 2'b11;

endpackage

// File: rtl/sio_shift_reg.sv
// Holds the {addr,data} word: LSB-first serial shift plus parallel load of the data field.
module sio_shift_reg #(
  parameter int unsigned REG_BITS_WIDTH    = 18,
  parameter int unsigned MEMORY_DATA_WIDTH = 8
) (
  input  logic                         csi_clk,
  input  logic                         rsi_reset_n,
  input  logic                         shift_en,
  input  logic                         si,
  input  logic                         cap_en,
  input  logic [MEMORY_DATA_WIDTH-1:0] cap_data,
  output logic [REG_BITS_WIDTH-1:0]    word,
  output logic                         so
);

  // Shift has priority; the FSM never asserts both enables together.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      word <= '0;
    end else if (shift_en) begin
      word <= {si, word[REG_BITS_WIDTH-1:1]};
    end else if (cap_en) begin
      word[MEMORY_DATA_WIDTH-1:0] <= cap_data;
    end
  end

  assign so = word[0];

endmodule

// File: rtl/sram_io_ctrl_chip.sv
// Serial-to-SRAM bridge: exchanges one {addr,data} word with the FPGA and
// performs single SRAM reads/writes at the held address.
module sram_io_ctrl_chip
  import sram_io_ctrl_chip_pkg::*;
#(
  parameter int unsigned MEMORY_DATA_WIDTH = DEF_MEMORY_DATA_WIDTH,
  parameter int unsigned MEMORY_ADDR_WIDTH = DEF_MEMORY_ADDR_WIDTH,
  parameter int unsigned REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH         = DEF_CNT_WIDTH
) (
  input  logic                         csi_clk,
  input  logic                         rsi_reset_n,
  input  logic                         ctrl_bgn,
  input  logic                         ctrl_load,
  input  logic                         ctrl_mod0,
  input  logic                         ctrl_mod1,
  input  logic                         ctrl_si,
  output logic                         ctrl_so,
  output logic                         ctrl_rdy,
  output logic                         sram_cen,
  output logic                         sram_wen,
  output logic [MEMORY_ADDR_WIDTH-1:0] sram_a,
  output logic [MEMORY_DATA_WIDTH-1:0] sram_d,
  input  logic [MEMORY_DATA_WIDTH-1:0] sram_q
);

  state_e                         state, state_nxt;
  logic [CNT_WIDTH-1:0]           cnt, cnt_nxt;
  logic                           bgn_q, load_q;
  logic                           rdy_nxt, cen_nxt, wen_nxt;
  logic [MEMORY_ADDR_WIDTH-1:0]   a_nxt;
  logic [MEMORY_DATA_WIDTH-1:0]   d_nxt;
  logic                           shift_en_c, cap_en_c;
  logic                           ld_rise_c, bg_rise_c;
  logic [1:0]                     mode_c;
  logic [REG_BITS_WIDTH-1:0]      word;
  logic [MEMORY_ADDR_WIDTH-1:0]   addr_c;
  logic [MEMORY_DATA_WIDTH-1:0]   data_c;

  assign ld_rise_c = ctrl_load & ~load_q;
  assign bg_rise_c = ctrl_bgn & ~bgn_q;
  assign mode_c    = {ctrl_mod1, ctrl_mod0};
  assign addr_c    = word[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH];
  assign data_c    = word[MEMORY_DATA_WIDTH-1:0];

  sio_shift_reg #(
    .REG_BITS_WIDTH   (REG_BITS_WIDTH),
    .MEMORY_DATA_WIDTH(MEMORY_DATA_WIDTH)
  ) u_shift (
    .csi_clk    (csi_clk),
    .rsi_reset_n(rsi_reset_n),
    .shift_en   (shift_en_c),
    .si         (ctrl_si),
    .cap_en     (cap_en_c),
    .cap_data   (sram_q),
    .word       (word),
    .so         (ctrl_so)
  );

  // State, counter, edge history and registered SRAM/handshake outputs.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bgn_q    <= 1'b0;
      load_q   <= 1'b0;
      ctrl_rdy <= 1'b1;
      sram_cen <= 1'b1;
      sram_wen <= 1'b1;
      sram_a   <= '0;
      sram_d   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bgn_q    <= ctrl_bgn;
      load_q   <= ctrl_load;
      ctrl_rdy <= rdy_nxt;
      sram_cen <= cen_nxt;
      sram_wen <= wen_nxt;
      sram_a   <= a_nxt;
      sram_d   <= d_nxt;
    end
  end

  // Next-state and next-output decode; mode only matters on the starting edge.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rdy_nxt    = ctrl_rdy;
    cen_nxt    = 1'b1;
    wen_nxt    = 1'b1;
    a_nxt      = sram_a;
    d_nxt      = sram_d;
    shift_en_c = 1'b0;
    cap_en_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ld_rise_c && (mode_c[0] == MODE_SER[0])) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = CNT_WIDTH'(REG_BITS_WIDTH);
          rdy_nxt   = 1'b0;
        end else if (bg_rise_c && (mode_c == MODE_RD)) begin
          state_nxt = ST_RD_REQ;
          cen_nxt   = 1'b0;
          a_nxt     = addr_c;
          rdy_nxt   = 1'b0;
        end else if (bg_rise_c && (mode_c == MODE_WR)) begin
          state_nxt = ST_WR_REQ;
          cen_nxt   = 1'b0;
          wen_nxt   = 1'b0;
          a_nxt     = addr_c;
          d_nxt     = data_c;
          rdy_nxt   = 1'b0;
        end
      end
      ST_SHIFT: begin
        shift_en_c = 1'b1;
        cnt_nxt    = cnt - CNT_WIDTH'(1);
        if (cnt == CNT_WIDTH'(1)) begin
          state_nxt = ST_IDLE;
          rdy_nxt   = 1'b1;
        end
      end
      ST_RD_REQ: begin
        state_nxt = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        cap_en_c  = 1'b1;
        state_nxt = ST_IDLE;
        rdy_nxt   = 1'b1;
      end
      ST_WR_REQ: begin
        state_nxt = ST_IDLE;
        rdy_nxt   = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        rdy_nxt   = 1'b1;
      end
    endcase
  end

endmodule
